// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one burst memory port between icache and dcache line requests
// Optional macro MEM_ARB_RR_EN: round-robin grant on simultaneous requests (default: dcache priority).
module mem_port_arbiter #(
   parameter int  BEAT_W    = 64,
   parameter int  BURST_LEN = 4,
   localparam int LINE_W    = BEAT_W * BURST_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [31:0]       d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [31:0]       bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [31:0]       bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [31:0]      LINE_MASK = ~32'(LINE_W / 8 - 1);

   typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_gnt_d;
   logic [31:0]       r_addr;
   logic [LINE_W-1:0] r_line, r_i_rdata, r_d_rdata, w_line_asm;
   logic              w_d_req, w_i_req, w_any_req, w_pick_d, w_beat_hit;

   assign w_d_req   = d_read | d_write;
   assign w_i_req   = i_read;
   assign w_any_req = w_d_req | w_i_req;

`ifdef MEM_ARB_RR_EN
   logic r_last_d;
   assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 r_last_d <= 1'b0;
      else if (r_state == RESP) r_last_d <= r_gnt_d;
   end
`else
   assign w_pick_d = w_d_req;
`endif

   // Only beats tagged with our line address count; anything else on the bus is foreign.
   assign w_beat_hit = bmem_rvalid & (bmem_raddr == r_addr);

   always_comb begin
      w_line_asm = r_line;
      w_line_asm[r_cnt*BEAT_W +: BEAT_W] = bmem_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      bmem_read   = 1'b0;
      bmem_write  = 1'b0;
      bmem_addr   = '0;
      bmem_wdata  = '0;
      i_resp      = 1'b0;
      d_resp      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) w_state_nxt = (w_pick_d & d_write) ? WR_DATA : RD_CMD;
         end
         RD_CMD: begin
            bmem_read = 1'b1;
            bmem_addr = r_addr;
            if (bmem_ready) w_state_nxt = RD_DATA;
         end
         RD_DATA: begin
            if (w_beat_hit && r_cnt == LAST_BEAT) w_state_nxt = RESP;
         end
         WR_DATA: begin
            bmem_write = 1'b1;
            bmem_addr  = r_addr;
            bmem_wdata = d_wdata[r_cnt*BEAT_W +: BEAT_W];
            if (bmem_ready && r_cnt == LAST_BEAT) w_state_nxt = RESP;
         end
         RESP: begin
            i_resp      = ~r_gnt_d;
            d_resp      = r_gnt_d;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_gnt_d   <= 1'b0;
         r_addr    <= '0;
         r_line    <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_gnt_d <= w_pick_d;
                  r_addr  <= (w_pick_d ? d_addr : i_addr) & LINE_MASK;
                  r_cnt   <= '0;
               end
            end
            RD_DATA: begin
               if (w_beat_hit) begin
                  r_line <= w_line_asm;
                  r_cnt  <= r_cnt + 1'b1;
                  // Publish the full line on the edge into RESP so rdata is valid with resp.
                  if (r_cnt == LAST_BEAT) begin
                     if (r_gnt_d) r_d_rdata <= w_line_asm;
                     else         r_i_rdata <= w_line_asm;
                  end
               end
            end
            WR_DATA: begin
               if (bmem_ready) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction scoreboard
module tb_mem_port_arbiter;
   localparam int BEAT_W = 64;
   localparam int BURST_LEN = 4;
   localparam int LINE_W = BEAT_W * BURST_LEN;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       i_addr, d_addr, bmem_addr, bmem_raddr;
   logic              i_read, i_resp, d_read, d_write, d_resp;
   logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
   logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid;
   logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;

   mem_port_arbiter #(.BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              side_d;
      logic              rd;
      logic [31:0]       addr;
      logic [LINE_W-1:0] line;
   } txn_t;

   txn_t              exp_q[$];
   txn_t              cur;
   logic [LINE_W-1:0] m_i_line, m_d_line;
   int                wr_idx;
   int                n_vec = 0;
   int                n_err = 0;
   int                cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic side_d, input logic rd, input logic [31:0] a, input logic [LINE_W-1:0] l);
      txn_t t;
      t.side_d = side_d; t.rd = rd; t.addr = a; t.line = l;
      exp_q.push_back(t);
   endtask

   function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] seed);
      logic [LINE_W-1:0] l;
      for (int k = 0; k < BURST_LEN; k++) l[k*BEAT_W +: BEAT_W] = seed + 64'(k) * 64'h0001_0001_0001_0001;
      return l;
   endfunction

   // Waits for an accepted read command, then steps into the first data cycle.
   task automatic wait_cmd(output int n, output logic [31:0] a);
      logic done;
      n = 0; a = '0; done = 1'b0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
         if (bmem_read && bmem_ready) begin
            a = bmem_addr;
            done = 1'b1;
         end
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL cmd_timeout: no bmem_read after %0d cycles", n);
      end else begin
         tick();
      end
   endtask

   task automatic wait_resp(input logic side_d, output int n);
      n = 0;
      while (((side_d ? d_resp : i_resp) !== 1'b1) && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) begin
         n_vec++; n_err++;
         $display("FAIL resp_timeout: side_d=%0d no resp after %0d cycles", side_d, n);
      end
   endtask

   task automatic send_beats(input logic [31:0] a, input logic [LINE_W-1:0] l, input int nb, input int bad_at);
      for (int k = 0; k < nb; k++) begin
         if (k == bad_at) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'hDEAD_0000; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
         end
         bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = l[k*BEAT_W +: BEAT_W];
         tick();
      end
      bmem_rvalid = 1'b0;
   endtask

   // Scoreboard: every cycle, outputs must agree with the transaction-level model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_i_rdata", i_rdata, '0);
         chk("rst_d_rdata", d_rdata, '0);
         chk("rst_ctl", {bmem_addr, bmem_wdata, i_resp, d_resp, bmem_read, bmem_write}, '0);
         m_i_line = '0; m_d_line = '0; wr_idx = 0;
         exp_q.delete();
      end else begin
         chk("resp_excl", i_resp & d_resp, '0);
         chk("cmd_excl", bmem_read & bmem_write, '0);
         if (exp_q.size() == 0) begin
            chk("idle_bmem", {bmem_addr, bmem_wdata, bmem_read, bmem_write, i_resp, d_resp}, '0);
         end else begin
            cur = exp_q[0];
            if (bmem_read || bmem_write) chk("bmem_addr", bmem_addr, cur.addr);
            if (bmem_write) begin
               chk("wr_beat", bmem_wdata, cur.line[wr_idx*BEAT_W +: BEAT_W]);
               if (bmem_ready) wr_idx++;
            end
            if (i_resp || d_resp) begin
               void'(exp_q.pop_front());
               chk("resp_side", d_resp, cur.side_d);
               if (cur.rd) begin
                  if (cur.side_d) m_d_line = cur.line;
                  else            m_i_line = cur.line;
               end else begin
                  chk("wr_beats_done", wr_idx, BURST_LEN);
               end
               wr_idx = 0;
            end
         end
         chk("i_rdata", i_rdata, m_i_line);
         chk("d_rdata", d_rdata, m_d_line);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, %0d vectors so far", n_vec);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int                n, c0;
      logic [31:0]       a;
      logic [LINE_W-1:0] l1, w2, l3d, l3i, l4, l5, l6;
      logic [6:0]        pat;
      logic              first_d, side;

      rst = 1'b0;
      i_read = 0; i_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
      bmem_ready = 1; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {i_resp, d_resp, bmem_read, bmem_write, bmem_addr}, '0);
      rst = 1'b1;
      tick();

      // icache read, ideal memory
      l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      push(1'b0, 1'b1, 32'h1000_0020, l1);
      c0 = cyc;
      i_addr = 32'h1000_0024; i_read = 1'b1;
      wait_cmd(n, a);
      chk("t1_cmd_delay", n, 2);
      chk("t1_bmem_addr", a, 32'h1000_0020);
      chk("t1_read_one_cycle", bmem_read, 1'b0);
      send_beats(32'h1000_0020, l1, 4, -1);
      wait_resp(1'b0, n);
      i_read = 1'b0;
      chk("t1_latency", cyc - c0, 2 + BURST_LEN);
      chk("t1_i_rdata", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      chk("t1_d_resp", d_resp, 1'b0);
      tick();
      chk("t1_resp_one_cycle", i_resp, 1'b0);

      // dcache write with beat 1 stalled for 3 cycles
      w2 = mk_line(64'hA000_0000_0000_0A00);
      push(1'b1, 1'b0, 32'h2000_0040, w2);
      c0 = cyc;
      d_addr = 32'h2000_0040; d_wdata = w2; d_write = 1'b1;
      tick();
      pat = 7'b111_0001;
      for (int c = 0; c < 7; c++) begin
         bmem_ready = pat[c];
         tick();
      end
      bmem_ready = 1'b1;
      wait_resp(1'b1, n);
      d_write = 1'b0;
      chk("t2_resp_after_last_accept", n, 0);
      chk("t2_latency", cyc - c0, 1 + BURST_LEN + 3);
      tick();
      chk("t2_resp_one_cycle", d_resp, 1'b0);

      // simultaneous reads
      l3d = mk_line(64'hD000_0000_0000_0D00);
      l3i = mk_line(64'hC000_0000_0000_0C00);
`ifdef MEM_ARB_RR_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      for (int t = 0; t < 2; t++) begin
         side = (t == 0) ? first_d : ~first_d;
         push(side, 1'b1, side ? 32'h4000_0000 : 32'h3000_0000, side ? l3d : l3i);
      end
      d_addr = 32'h4000_0010; i_addr = 32'h3000_0000;
      d_read = 1'b1; i_read = 1'b1;
      for (int t = 0; t < 2; t++) begin
         side = (t == 0) ? first_d : ~first_d;
         wait_cmd(n, a);
         chk("t3_cmd_delay", n, (t == 0) ? 2 : 3);
         chk("t3_order_addr", a, side ? 32'h4000_0000 : 32'h3000_0000);
         send_beats(a, side ? l3d : l3i, 4, -1);
         wait_resp(side, n);
         chk("t3_resp_delay", n, 0);
         if (side) d_read = 1'b0;
         else      i_read = 1'b0;
      end
      tick();

      // mismatched beat tag ignored
      l4 = mk_line(64'h5555_0000_0000_0500);
      push(1'b1, 1'b1, 32'h5000_0000, l4);
      d_addr = 32'h5000_0000; d_read = 1'b1;
      wait_cmd(n, a);
      send_beats(32'h5000_0000, l4, 4, 2);
      wait_resp(1'b1, n);
      d_read = 1'b0;
      chk("t4_resp_delay", n, 0);
      chk("t4_beat2", d_rdata[2*BEAT_W +: BEAT_W], 64'h5557_0002_0002_0502);
      tick();

      // reset during beat 2, then stray beats in IDLE, then a fresh read
      push(1'b1, 1'b1, 32'h6000_0000, mk_line(64'h6666_0000_0000_0600));
      d_addr = 32'h6000_0000; d_read = 1'b1;
      wait_cmd(n, a);
      send_beats(32'h6000_0000, mk_line(64'h6666_0000_0000_0600), 2, -1);
      bmem_rvalid = 1'b1; bmem_raddr = 32'h6000_0000; bmem_rdata = 64'h6668_0002_0002_0602;
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_i_rdata", i_rdata, '0);
      chk("t5_async_d_rdata", d_rdata, '0);
      chk("t5_async_ctl", {bmem_addr, bmem_wdata, i_resp, d_resp, bmem_read, bmem_write}, '0);
      d_read = 1'b0; bmem_rvalid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      l5 = mk_line(64'h7777_0000_0000_0700);
      for (int k = 0; k < 3; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h7000_0000; bmem_rdata = 64'hFFFF_0000_FFFF_0000;
         tick();
      end
      bmem_rvalid = 1'b0;
      chk("t5_stray_no_cmd", bmem_read, 1'b0);
      push(1'b1, 1'b1, 32'h7000_0000, l5);
      d_addr = 32'h7000_0000; d_read = 1'b1;
      wait_cmd(n, a);
      send_beats(32'h7000_0000, l5, 4, -1);
      wait_resp(1'b1, n);
      d_read = 1'b0;
      chk("t5_fresh_line", d_rdata, l5);
      tick();

      // request dropped after the command
      l6 = mk_line(64'h8888_0000_0000_0800);
      push(1'b0, 1'b1, 32'h8000_0040, l6);
      i_addr = 32'h8000_0040; i_read = 1'b1;
      wait_cmd(n, a);
      i_read = 1'b0;
      send_beats(32'h8000_0040, l6, 4, -1);
      wait_resp(1'b0, n);
      chk("t6_resp_delay", n, 0);
      tick();
      chk("t6_resp_one_cycle", i_resp, 1'b0);
      repeat (3) tick();
      chk("t6_no_new_cmd", {bmem_read, bmem_write, i_resp}, '0);
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single burst memory port (bmem_*) between the instruction-side and data-side line requesters (icache, dcache).
- Each requester presents a whole cache-line read or write.
- The arbiter grants one requester, sequences the BURST_LEN-beat transfer on bmem, assembles or serialises the line, and returns a one-cycle resp.
- Sits between both caches and the top-level bmem ports of cpu.

Parameters:
BEAT_W, 64, bmem data beat width in bits
BURST_LEN, 4, beats per line; line width LINE_W = BEAT_W*BURST_LEN (256)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_addr  in  32  icache line address
i_read  in  1  icache read request; level, held until i_resp
i_rdata  out  LINE_W  returned line, valid with i_resp
i_resp  out  1  one-cycle completion pulse to icache
d_addr  in  32  dcache line address
d_read  in  1  dcache read request; level, held until d_resp
d_write  in  1  dcache write request; level, held until d_resp
d_wdata  in  LINE_W  dcache writeback line, beat 0 = bits [BEAT_W-1:0]
d_rdata  out  LINE_W  returned line, valid with d_resp
d_resp  out  1  one-cycle completion pulse to dcache
bmem_addr  out  32  line address, low log2(LINE_W/8) bits forced to 0
bmem_read  out  1  read command
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_W  write beat data
bmem_ready  in  1  memory accepts command/beat this cycle
bmem_raddr  in  32  address tag of returning read beat
bmem_rdata  in  BEAT_W  read beat data
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, last_grant=instruction. All outputs 0, including bmem_addr, bmem_wdata, i_rdata and d_rdata.
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE arbitration, sampled each cycle:
  - Data request = d_read|d_write; instruction request = i_read.
  - If only one is requesting, grant it.
  - If both are requesting, the dcache wins (fixed priority; see optional feature).
  - Latch grant, address and kind. If d_read and d_write are both high, the write wins.
  - Read → RD_CMD; write → WR_DATA with beat counter 0.
  - No request → stay in IDLE with all bmem outputs 0.
- RD_CMD: bmem_read=1, bmem_addr=latched line address. Hold until a cycle with bmem_ready=1, then go to RD_DATA.
- RD_DATA:
  - Each cycle with bmem_rvalid=1 and bmem_raddr equal to the latched line address, store bmem_rdata in beat slot[counter] and increment the counter.
  - Beats with a mismatched raddr are ignored.
  - When the beat with counter=BURST_LEN-1 is stored, go to RESP.
- WR_DATA:
  - bmem_write=1, bmem_addr=line address, bmem_wdata=d_wdata beat[counter].
  - Each cycle with bmem_ready=1 advances the counter.
  - Acceptance of beat BURST_LEN-1 → RESP.
- RESP: exactly one cycle.
  - The granted requester's resp=1. For reads, its rdata = the assembled line, held stable until its next resp.
  - Update last_grant, then go to IDLE. No new grant is made in the RESP cycle.
- Latency with an ideal memory (ready always 1, first beat one cycle after the command):
  - Read: grant cycle → resp after 2+BURST_LEN cycles.
  - Write: resp after 1+BURST_LEN cycles.
- Only one transaction is outstanding at a time. Dropping a request mid-transaction does not abort it; the transfer completes and resp still pulses.
- Stray bmem_rvalid outside RD_DATA is ignored.
- Reset asserted mid-burst returns immediately to IDLE, and beats already collected are discarded.
- i_resp and d_resp are never high in the same cycle. bmem_read and bmem_write are never high in the same cycle.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: when both sides request in IDLE, grant the side that is not last_grant (round-robin). last_grant updates in RESP.
- Undefined: fixed dcache priority; last_grant is unused.

Test Plan:
- Idle icache read: i_read=1, i_addr=0x1000_0024, ready=1, 4 beats 0x11..,0x22..,0x33..,0x44.. at raddr 0x1000_0020 → bmem_addr=0x1000_0020, bmem_read for 1 cycle, i_resp 1 cycle, i_rdata={0x44..,0x33..,0x22..,0x11..}, d_resp=0.
- Dcache write with stalls: d_write=1, d_addr=0x2000_0040, bmem_ready low on beat 1 for 3 cycles → each beat is held until accepted, 4 bmem_write beats in order, d_resp exactly 1 cycle after the last accept.
- Simultaneous i_read and d_read in IDLE → dcache is served first; the icache is served immediately after d_resp. With MEM_ARB_RR_EN and last_grant=data, the icache is served first.
- Mismatched read beat: during RD_DATA inject rvalid with raddr=0xDEAD_0000 → the beat is ignored, the counter is unchanged, and the line contains only the matching beats.
- Reset during beat 2 of a read → all outputs 0 in the same cycle (async). After release, a fresh d_read completes correctly, and stray rvalid beats in IDLE are ignored.
- Request dropped mid-read: i_read lowered after RD_CMD → the burst completes and i_resp still pulses once.
